chip_nco: RTL and testbench
===========================

CHIP_NCO -- requirements
Module: chip_nco

Interface
REQ-001 Parameter ACC_W, default 32, phase-accumulator width in bits.
REQ-002 Parameter FCW_RESET, default 438945658, frequency control word after reset (round(0.511 MHz / 5 MHz * 2^32)).
REQ-003 Parameter CHIPS_PER_EPOCH, default 511, chips per code epoch; legal range 2..65535.
REQ-004 Parameter CNT_W, default 9, chip-counter width; SHALL satisfy 2^CNT_W >= CHIPS_PER_EPOCH.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  accumulate enable.
REQ-008 sync_clr  in  1  synchronous phase/epoch clear.
REQ-009 fcw_in  in  ACC_W  new frequency control word.
REQ-010 fcw_load  in  1  single-cycle request to capture fcw_in.
REQ-011 fcw_busy  out  1  captured FCW not yet applied.
REQ-012 clk_out  out  1  chip-rate square wave (accumulator MSB, registered).
REQ-013 chip_stb  out  1  one-cycle pulse per chip.
REQ-014 chip_cnt  out  CNT_W  chip index within epoch.
REQ-015 epoch_stb  out  1  one-cycle pulse on epoch wrap.

Function
REQ-016 Each cycle with en=1 and sync_clr=0, {carry, acc} SHALL become acc + fcw_active, computed ACC_W+1 bits wide, modulo 2^ACC_W.
REQ-017 chip_stb SHALL be the registered carry: high exactly the cycle after the accumulate that overflowed.
REQ-018 clk_out SHALL equal the registered accumulator MSB, one cycle after the accumulate.
REQ-019 On each chip_stb assertion, chip_cnt SHALL update in the same cycle: +1, or 0 when its old value is CHIPS_PER_EPOCH-1.
REQ-020 epoch_stb SHALL be high exactly in the cycle in which chip_cnt wraps to 0 because of a chip.
REQ-021 With en=0, acc, chip_cnt and clk_out SHALL hold, and chip_stb and epoch_stb SHALL be 0.
REQ-022 fcw_load=1 SHALL capture fcw_in into fcw_pending and set fcw_busy the following cycle.
REQ-023 fcw_pending SHALL become fcw_active on the first cycle in which an accumulate produces a carry; the carry-producing add itself still uses the old word, and fcw_busy clears the next cycle.
REQ-024 fcw_load while fcw_busy=1 SHALL overwrite fcw_pending (latest wins).
REQ-025 fcw_load in the same cycle as an applying carry SHALL leave the new word pending with fcw_busy=1.
REQ-026 sync_clr=1 SHALL take priority over en and SHALL, on the next edge, clear acc, clk_out, chip_cnt, chip_stb and epoch_stb to 0.
REQ-027 sync_clr=1 SHALL apply any pending FCW immediately and clear fcw_busy.
REQ-028 sync_clr=1 together with fcw_load SHALL apply fcw_in directly.
REQ-029 fcw_in=0 SHALL be legal: no chips are produced.
REQ-030 The maximum chip rate SHALL be one chip per cycle, reached with fcw near 2^ACC_W-1.

Reset
REQ-031 While rst=1: acc=0, fcw_active=FCW_RESET, fcw_pending=FCW_RESET, fcw_busy=0, clk_out=0, chip_stb=0, chip_cnt=0, epoch_stb=0.
REQ-032 Reset asserted mid-operation SHALL take effect immediately, without waiting for clk.
REQ-033 On release, the first accumulate SHALL occur on the first rising edge with en=1.

Structure
REQ-034 Shared package glo_nco_pkg SHALL hold GLO_ACC_W=32, GLO_FCW_511K_5M=438945658 and GLO_CHIPS_PER_EPOCH=511.
REQ-035 One sub-module, nco_phase_acc, SHALL contain the accumulator, carry, MSB and FCW staging.
REQ-036 chip_nco SHALL contain the epoch counter and strobes.

Verification
REQ-037 Default parameters, en=1, 5,000,000 cycles -> chip_stb count in [510999, 511001] and epoch_stb count = 1000.
REQ-038 fcw=2^31 after sync_clr, en=1 -> chip_stb every 2nd cycle, clk_out toggles every cycle, epoch_stb period 1022 cycles.
REQ-039 fcw=2^30, fcw_load of 2^31 mid-chip -> fcw_busy=1 until the next carry, then the chip period changes from 4 to 2 with no missing or extra chip.
REQ-040 sync_clr in the same cycle as a carry, with chip_cnt=510 -> next cycle all outputs 0, no chip_stb or epoch_stb.
REQ-041 Two fcw_loads while busy, then en=0 for 100 cycles -> outputs frozen, last word applied at the first carry after en returns.
REQ-042 rst pulsed asynchronously between edges mid-epoch -> outputs immediately at reset values and fcw_active=FCW_RESET.

Source files
------------

// File: rtl/glo_nco_pkg.sv
// Shared constants for the chip-rate NCO family (GNSS-style 511-chip codes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   GLO_ACC_W            phase-accumulator width
//   GLO_FCW_511K_5M      FCW giving 0.511 MHz chips from a 5 MHz clock
//   GLO_CHIPS_PER_EPOCH  chips per code epoch
//   GLO_CNT_W            chip-counter width able to hold GLO_CHIPS_PER_EPOCH-1
//   nco_min_cnt_w()      smallest counter width for a given epoch length
package glo_nco_pkg;

    localparam int          GLO_ACC_W           = 32;
    // round(0.511e6 / 5e6 * 2^32)
    localparam int unsigned GLO_FCW_511K_5M     = 32'd438945658;
    localparam int          GLO_CHIPS_PER_EPOCH = 511;
    localparam int          GLO_CNT_W           = 9;

    // Width needed to count 0 .. chips-1.
    function automatic int nco_min_cnt_w(input int chips);
        return $clog2(chips);
    endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator with carry/MSB registers and glitch-free FCW staging.
// Latency: carry_o and msb_o are registered, one cycle after the accumulate.
// Backpressure: none; en_i freezes phase, sync_clr_i restarts it.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   en_i             accumulate enable
//   sync_clr_i       synchronous phase clear (also applies any pending FCW)
//   fcw_i/fcw_load_i new frequency control word and its one-cycle load strobe
//   fcw_busy_o       a loaded FCW is waiting for the next carry
//   msb_o            registered accumulator MSB (chip-rate square wave)
//   carry_o          registered carry (one-cycle chip strobe)
//   carry_now_o      combinational carry of the accumulate happening this cycle
module nco_phase_acc
    import glo_nco_pkg::*;
#(
    parameter int               ACC_W     = GLO_ACC_W,
    parameter logic [ACC_W-1:0] FCW_RESET = ACC_W'(GLO_FCW_511K_5M)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_clr_i,
    input  logic [ACC_W-1:0] fcw_i,
    input  logic             fcw_load_i,
    output logic             fcw_busy_o,
    output logic             msb_o,
    output logic             carry_o,
    output logic             carry_now_o
);

    logic [ACC_W-1:0] acc_q,         acc_d;
    logic [ACC_W-1:0] fcw_active_q,  fcw_active_d;
    logic [ACC_W-1:0] fcw_pending_q, fcw_pending_d;
    logic             busy_q,        busy_d;
    logic             msb_q,         msb_d;
    logic             carry_q,       carry_d;

    // One extra bit so the overflow of the add is the chip event.
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, fcw_active_q};

    always_comb begin
        acc_d         = acc_q;
        msb_d         = msb_q;
        carry_d       = 1'b0;
        fcw_active_d  = fcw_active_q;
        fcw_pending_d = fcw_pending_q;
        busy_d        = busy_q;

        if (sync_clr_i) begin
            // Phase restarts at zero, so there is no chip boundary to protect:
            // the newest word (a simultaneous load wins) goes live at once.
            acc_d         = '0;
            msb_d         = 1'b0;
            fcw_active_d  = fcw_load_i ? fcw_i : fcw_pending_q;
            fcw_pending_d = fcw_active_d;
            busy_d        = 1'b0;
        end else begin
            if (en_i) begin
                acc_d   = sum[ACC_W-1:0];
                msb_d   = sum[ACC_W-1];
                carry_d = sum[ACC_W];
            end
            // Swap words only on a chip boundary so no chip is stretched or
            // split. The overflowing add itself used the old word above.
            if (carry_d && busy_q) begin
                fcw_active_d = fcw_pending_q;
                busy_d       = 1'b0;
            end
            // A load arriving with the applying carry stays pending for the
            // next boundary rather than being swallowed.
            if (fcw_load_i) begin
                fcw_pending_d = fcw_i;
                busy_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q         <= '0;
            fcw_active_q  <= FCW_RESET;
            fcw_pending_q <= FCW_RESET;
            busy_q        <= 1'b0;
            msb_q         <= 1'b0;
            carry_q       <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            fcw_active_q  <= fcw_active_d;
            fcw_pending_q <= fcw_pending_d;
            busy_q        <= busy_d;
            msb_q         <= msb_d;
            carry_q       <= carry_d;
        end
    end

    assign fcw_busy_o  = busy_q;
    assign msb_o       = msb_q;
    assign carry_o     = carry_q;
    assign carry_now_o = carry_d;

endmodule

// File: rtl/chip_nco.sv
// Chip-rate NCO: phase accumulator plus chip-in-epoch counter and strobes.
// Latency: chip_stb/chip_cnt/epoch_stb/clk_out all appear one cycle after the accumulate.
// Backpressure: none; en holds all state, sync_clr restarts phase and epoch.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 accumulate enable
//   sync_clr           synchronous phase/epoch clear
//   fcw_in, fcw_load   new frequency control word and its load strobe
//   fcw_busy           loaded word not yet applied
//   clk_out            chip-rate square wave
//   chip_stb           one-cycle pulse per chip
//   chip_cnt           chip index within epoch
//   epoch_stb          one-cycle pulse when chip_cnt wraps to 0
module chip_nco
    import glo_nco_pkg::*;
#(
    parameter int               ACC_W           = GLO_ACC_W,
    parameter logic [ACC_W-1:0] FCW_RESET       = ACC_W'(GLO_FCW_511K_5M),
    parameter int               CHIPS_PER_EPOCH = GLO_CHIPS_PER_EPOCH,
    parameter int               CNT_W           = GLO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [ACC_W-1:0] fcw_in,
    input  logic             fcw_load,
    output logic             fcw_busy,
    output logic             clk_out,
    output logic             chip_stb,
    output logic [CNT_W-1:0] chip_cnt,
    output logic             epoch_stb
);

    if (CHIPS_PER_EPOCH < 2 || CHIPS_PER_EPOCH > 65535 ||
        CNT_W < nco_min_cnt_w(CHIPS_PER_EPOCH)) begin : g_param_err
        $error("chip_nco: CHIPS_PER_EPOCH out of range or CNT_W too narrow");
    end

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS_PER_EPOCH - 1);

    logic             carry_now;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             epoch_q, epoch_d;

    nco_phase_acc #(
        .ACC_W     (ACC_W),
        .FCW_RESET (FCW_RESET)
    ) u_acc (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .sync_clr_i  (sync_clr),
        .fcw_i       (fcw_in),
        .fcw_load_i  (fcw_load),
        .fcw_busy_o  (fcw_busy),
        .msb_o       (clk_out),
        .carry_o     (chip_stb),
        .carry_now_o (carry_now)
    );

    // The counter advances on the same edge that registers the carry, so
    // chip_cnt changes in exactly the cycle chip_stb is high.
    always_comb begin
        cnt_d   = cnt_q;
        epoch_d = 1'b0;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (carry_now) begin
            if (cnt_q == LAST_CHIP) begin
                cnt_d   = '0;
                epoch_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            epoch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            epoch_q <= epoch_d;
        end
    end

    assign chip_cnt  = cnt_q;
    assign epoch_stb = epoch_q;

endmodule

// File: tb/tb_chip_nco.sv
module tb_chip_nco;

    localparam logic [31:0] FCW_DEF = 32'd438945658;
    localparam logic [31:0] F_HALF  = 32'h8000_0000;
    localparam logic [31:0] F_QTR   = 32'h4000_0000;
    localparam logic [31:0] F_8TH   = 32'h2000_0000;
    localparam logic [31:0] F_MAX   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic [31:0] fcw_in;
    logic        fcw_load;
    logic        fcw_busy;
    logic        clk_out;
    logic        chip_stb;
    logic [8:0]  chip_cnt;
    logic        epoch_stb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chip_nco dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .fcw_in    (fcw_in),
        .fcw_load  (fcw_load),
        .fcw_busy  (fcw_busy),
        .clk_out   (clk_out),
        .chip_stb  (chip_stb),
        .chip_cnt  (chip_cnt),
        .epoch_stb (epoch_stb)
    );

    typedef struct packed {
        logic       busy;
        logic       clk;
        logic       stb;
        logic [8:0] cnt;
        logic       ep;
    } obs_t;

    obs_t sb_q[$];

    // Reference model state
    logic [31:0] m_acc, m_fa, m_fp;
    logic        m_busy, m_clk, m_stb, m_ep;
    logic [8:0]  m_cnt;

    task automatic model_reset();
        m_acc  = '0;
        m_fa   = FCW_DEF;
        m_fp   = FCW_DEF;
        m_busy = 1'b0;
        m_clk  = 1'b0;
        m_stb  = 1'b0;
        m_ep   = 1'b0;
        m_cnt  = '0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic e, input logic c, input logic [31:0] f, input logic l);
        logic [32:0] s;
        logic        cy;
        cy   = 1'b0;
        m_ep = 1'b0;
        if (c) begin
            m_fa   = l ? f : m_fp;
            m_fp   = m_fa;
            m_busy = 1'b0;
            m_acc  = '0;
            m_clk  = 1'b0;
            m_cnt  = '0;
        end else begin
            if (e) begin
                s     = {1'b0, m_acc} + {1'b0, m_fa};
                m_acc = s[31:0];
                m_clk = s[31];
                cy    = s[32];
                if (cy) begin
                    if (m_cnt == 9'd510) begin
                        m_cnt = '0;
                        m_ep  = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 9'd1;
                    end
                end
            end
            if (cy && m_busy) begin
                m_fa   = m_fp;
                m_busy = 1'b0;
            end
            if (l) begin
                m_fp   = f;
                m_busy = 1'b1;
            end
        end
        m_stb = cy;
        sb_q.push_back({m_busy, m_clk, m_stb, m_cnt, m_ep});
    endtask

    // Apply one cycle of stimulus at the falling edge and queue its expectation.
    task automatic drive(input logic e, input logic c, input logic [31:0] f, input logic l);
        @(negedge clk);
        en       = e;
        sync_clr = c;
        fcw_in   = f;
        fcw_load = l;
        model_step(e, c, f, l);
    endtask

    // Scoreboard: every rising edge consumes the expectation queued before it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                obs_t e;
                obs_t g;
                e = sb_q.pop_front();
                g = {fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got busy/clk/stb/cnt/ep=%b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
                             $time, g.busy, g.clk, g.stb, g.cnt, g.ep, e.busy, e.clk, e.stb, e.cnt, e.ep);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; fcw_in = '0; fcw_load = 1'b0;
        model_reset();
        #1;
        total++;
        if ({fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb});
        end
        total++;
        if (dut.u_acc.fcw_active_q !== FCW_DEF) begin
            bad++;
            $display("FAIL reset_fcw got=%0d want=%0d", dut.u_acc.fcw_active_q, FCW_DEF);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 5000 cycles at the default word is exactly 1/1000 of the 5 MHz second.
    task automatic test_default_rate();
        int chips  = 0;
        int epochs = 0;
        for (int i = 0; i < 5000; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            chips  += int'(chip_stb);
            epochs += int'(epoch_stb);
        end
        total++;
        if (chips !== 511) begin
            bad++;
            $display("FAIL default_chips got=%0d want=511", chips);
        end
        total++;
        if (epochs !== 1) begin
            bad++;
            $display("FAIL default_epochs got=%0d want=1", epochs);
        end
        total++;
        if (chip_cnt !== 9'd0) begin
            bad++;
            $display("FAIL default_cnt_end got=%0d want=0", chip_cnt);
        end
    endtask

    task automatic test_half_rate();
        int pat_err = 0;
        int ep_n    = 0;
        int ep_first = -1;
        int ep_second = -1;
        drive(1'b0, 1'b1, F_HALF, 1'b1);
        for (int i = 0; i < 2100; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            if (chip_stb !== (i % 2 == 1) || clk_out !== (i % 2 == 0)) pat_err++;
            if (epoch_stb === 1'b1) begin
                ep_n++;
                if (ep_first < 0) ep_first = i;
                else if (ep_second < 0) ep_second = i;
            end
        end
        total++;
        if (pat_err !== 0) begin
            bad++;
            $display("FAIL half_pattern got=%0d bad cycles want=0", pat_err);
        end
        total++;
        if (ep_first !== 1021 || ep_n !== 2) begin
            bad++;
            $display("FAIL half_epoch_first got=%0d (count %0d) want=1021 (count 2)", ep_first, ep_n);
        end
        total++;
        if (ep_second - ep_first !== 1022) begin
            bad++;
            $display("FAIL half_epoch_period got=%0d want=1022", ep_second - ep_first);
        end
    endtask

    task automatic test_fcw_switch();
        logic stb_e, busy_e;
        drive(1'b0, 1'b1, F_QTR, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b0, F_HALF, k == 6);
            @(posedge clk);
            #2;
            stb_e  = (k == 4) || (k >= 8 && k % 2 == 0);
            busy_e = (k == 6) || (k == 7);
            total++;
            if ({fcw_busy, chip_stb} !== {busy_e, stb_e}) begin
                bad++;
                $display("FAIL switch_k%0d got busy/stb=%b/%b want %b/%b", k, fcw_busy, chip_stb, busy_e, stb_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, F_QTR, 1'b1);
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, F_HALF, 1'b1);
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, F_8TH, 1'b1);
        @(posedge clk);
        #2;
        total++;
        if ({fcw_busy, chip_stb} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_load_on_carry got busy/stb=%b/%b want 1/1", fcw_busy, chip_stb);
        end
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        total++;
        if ({fcw_busy, chip_stb} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_second_apply got busy/stb=%b/%b want 0/1", fcw_busy, chip_stb);
        end
    endtask

    task automatic test_clr_on_carry();
        drive(1'b0, 1'b1, F_HALF, 1'b1);
        for (int i = 0; i < 1021; i++) drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        total++;
        if (chip_cnt !== 9'd510 || clk_out !== 1'b1) begin
            bad++;
            $display("FAIL clr_precond got cnt/clk=%0d/%b want 510/1", chip_cnt, clk_out);
        end
        drive(1'b1, 1'b1, '0, 1'b0);
        @(posedge clk);
        #2;
        total++;
        if ({fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb} !== 13'd0) begin
            bad++;
            $display("FAIL clr_on_carry got=%b want=0", {fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb});
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_multi_load_freeze();
        int frz_err = 0;
        logic stb_e;
        drive(1'b0, 1'b1, F_QTR, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, F_8TH, 1'b1);
        drive(1'b0, 1'b0, F_HALF, 1'b1);
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            if ({fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb} !== {1'b1, 1'b1, 1'b0, 9'd2, 1'b0}) frz_err++;
        end
        total++;
        if (frz_err !== 0) begin
            bad++;
            $display("FAIL freeze got=%0d changed cycles want=0", frz_err);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            stb_e = (k % 2 == 0);
            total++;
            if ({fcw_busy, chip_stb} !== {k == 1, stb_e}) begin
                bad++;
                $display("FAIL latest_wins_k%0d got busy/stb=%b/%b want %b/%b", k, fcw_busy, chip_stb, k == 1, stb_e);
            end
        end
        total++;
        if (chip_cnt !== 9'd6) begin
            bad++;
            $display("FAIL latest_wins_cnt got=%0d want=6", chip_cnt);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        total++;
        if (chip_cnt !== 9'd7) begin
            bad++;
            $display("FAIL areset_precond got cnt=%0d want=7", chip_cnt);
        end
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0;
        #1;
        total++;
        if ({fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb} !== 13'd0) begin
            bad++;
            $display("FAIL areset_outputs got=%b want=0", {fcw_busy, clk_out, chip_stb, chip_cnt, epoch_stb});
        end
        total++;
        if (dut.u_acc.fcw_active_q !== FCW_DEF || dut.u_acc.fcw_pending_q !== FCW_DEF) begin
            bad++;
            $display("FAIL areset_fcw got active/pending=%0d/%0d want %0d", dut.u_acc.fcw_active_q,
                     dut.u_acc.fcw_pending_q, FCW_DEF);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_extreme_fcw();
        int chips = 0;
        drive(1'b0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            chips += int'(chip_stb);
        end
        total++;
        if (chips !== 0) begin
            bad++;
            $display("FAIL zero_fcw got=%0d chips want=0", chips);
        end
        chips = 0;
        drive(1'b0, 1'b1, F_MAX, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            @(posedge clk);
            #2;
            chips += int'(chip_stb);
        end
        total++;
        if (chips !== 9) begin
            bad++;
            $display("FAIL max_fcw got=%0d chips want=9", chips);
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       f = $urandom;
                1:       f = F_HALF;
                2:       f = F_MAX;
                default: f = 32'hC000_0000;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, f, $urandom_range(0, 5) == 0);
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_half_rate();
        test_fcw_switch();
        test_back_to_back();
        test_clr_on_carry();
        test_multi_load_freeze();
        test_async_reset();
        test_extreme_fcw();
        test_random();
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
